// File: rtl/axil_led_ctrl.sv
// AXI4-Lite LED controller: per-channel off/on/PWM/blink driven from a shared prescaled tick.
// Blink mode (MODE 3, HALF field) is built only when AXIL_LED_CTRL_BLINK_EN is defined.
module axil_led_ctrl #(
    parameter int unsigned NUM_LEDS     = 4,
    parameter int unsigned ADDR_W       = 7,
    parameter logic [15:0] PRESCALE_RST = 16'd99
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [2:0]          S_AXI_AWPROT,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [2:0]          S_AXI_ARPROT,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [31:0]         S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    output logic [NUM_LEDS-1:0] LED
);
    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_PWM, MODE_BLINK} mode_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned CH_BASE     = 4;
    localparam logic [31:0] ID_VAL      = 32'h4C45_0000 | 32'(NUM_LEDS);

    logic                awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [31:0]         rdata_q;
    logic                en_q;
    logic [15:0]         prescale_q, presc_cnt_q;
    logic [7:0]          pwm_cnt_q;
    mode_e               mode_q [NUM_LEDS];
    logic [7:0]          duty_q [NUM_LEDS];
`ifdef AXIL_LED_CTRL_BLINK_EN
    logic [15:0]         half_q      [NUM_LEDS];
    logic [15:0]         blink_cnt_q [NUM_LEDS];
    logic [NUM_LEDS-1:0] phase_q;
`endif
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic [31:0] wr_word, rd_word, rd_data_d;
    logic        wr_hs, rd_hs, wr_ok, wr_cmt, tick, rd_err_d;
    logic        unused_inputs;

    // Ready is registered so it is 0 straight out of reset; handshake happens in the cycle it is high.
    assign wr_hs   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs   = arready_q && S_AXI_ARVALID;
    assign wr_word = 32'(S_AXI_AWADDR[ADDR_W-1:2]);
    assign rd_word = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
    assign wr_ok   = (wr_word < CH_BASE + NUM_LEDS) && (wr_word != 32'd2) && (wr_word != 32'd3);
    assign wr_cmt  = wr_hs && wr_ok;
    assign tick    = en_q && (presc_cnt_q == prescale_q);

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                             S_AXI_WDATA, S_AXI_WSTRB};

    always_comb begin
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        if (rd_word == 32'd0) rd_data_d[0] = en_q;
        else if (rd_word == 32'd1) rd_data_d[15:0] = prescale_q;
        else if (rd_word == 32'd2) rd_data_d[NUM_LEDS-1:0] = led_q;
        else if (rd_word == 32'd3) rd_data_d = ID_VAL;
        else if (rd_word >= CH_BASE + NUM_LEDS) rd_err_d = 1'b1;
        else begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (rd_word == CH_BASE + i) begin
                    rd_data_d[1:0]  = mode_q[i];
                    rd_data_d[15:8] = duty_q[i];
`ifdef AXIL_LED_CTRL_BLINK_EN
                    rd_data_d[31:16] = half_q[i];
`endif
                end
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            case (mode_q[i])
                MODE_ON:    led_d[i] = 1'b1;
                MODE_PWM:   led_d[i] = pwm_cnt_q < duty_q[i];
`ifdef AXIL_LED_CTRL_BLINK_EN
                MODE_BLINK: led_d[i] = phase_q[i];
`endif
                default:    led_d[i] = 1'b0;
            endcase
        end
        if (!en_q) led_d = '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            en_q        <= 1'b0;
            prescale_q  <= PRESCALE_RST;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                duty_q[i] <= '0;
`ifdef AXIL_LED_CTRL_BLINK_EN
                half_q[i]      <= '0;
                blink_cnt_q[i] <= '0;
                phase_q[i]     <= 1'b0;
`endif
            end
        end else begin
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_d;
                rresp_q  <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end

            if (wr_cmt) begin
                if (wr_word == 32'd0 && S_AXI_WSTRB[0]) en_q <= S_AXI_WDATA[0];
                if (wr_word == 32'd1) begin
                    if (S_AXI_WSTRB[0]) prescale_q[7:0]  <= S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) prescale_q[15:8] <= S_AXI_WDATA[15:8];
                end
                for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                    if (wr_word == CH_BASE + i) begin
                        if (S_AXI_WSTRB[0]) mode_q[i] <= mode_e'(S_AXI_WDATA[1:0]);
                        if (S_AXI_WSTRB[1]) duty_q[i] <= S_AXI_WDATA[15:8];
`ifdef AXIL_LED_CTRL_BLINK_EN
                        if (S_AXI_WSTRB[2]) half_q[i][7:0]  <= S_AXI_WDATA[23:16];
                        if (S_AXI_WSTRB[3]) half_q[i][15:8] <= S_AXI_WDATA[31:24];
`endif
                    end
                end
            end

            if (!en_q || (wr_cmt && wr_word == 32'd1)) presc_cnt_q <= '0;
            else if (tick)                              presc_cnt_q <= '0;
            else                                        presc_cnt_q <= presc_cnt_q + 16'd1;

            if (!en_q)     pwm_cnt_q <= '0;
            else if (tick) pwm_cnt_q <= pwm_cnt_q + 8'd1;

`ifdef AXIL_LED_CTRL_BLINK_EN
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (!en_q || (wr_cmt && wr_word == CH_BASE + i)) begin
                    blink_cnt_q[i] <= '0;
                    phase_q[i]     <= 1'b0;
                end else if (tick) begin
                    if (blink_cnt_q[i] == half_q[i]) begin
                        blink_cnt_q[i] <= '0;
                        phase_q[i]     <= ~phase_q[i];
                    end else begin
                        blink_cnt_q[i] <= blink_cnt_q[i] + 16'd1;
                    end
                end
            end
`endif

            led_q <= led_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign LED           = led_q;

endmodule

// File: doc/axil_led_ctrl.md
AXIL_LED_CTRL -- requirements
Module: axil_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of LED channels, legal range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 7, AXI4-Lite byte address width.
REQ-003 SHALL have parameter PRESCALE_RST, default 16'd99, reset value of PRESCALE.
REQ-004 SHALL have port ACLK, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port ARESET, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have write-address ports: S_AXI_AWADDR in ADDR_W, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-007 SHALL have write-data ports: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-008 SHALL have write-response ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-009 SHALL have read-address ports: S_AXI_ARADDR in ADDR_W, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
REQ-010 SHALL have read-data ports: S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-011 SHALL have port LED, output, NUM_LEDS bits, registered LED drive, 1 = on.

Function
REQ-012 Register map (32-bit words): 0x00 CTRL (bit0 EN, RW); 0x04 PRESCALE ([15:0], RW); 0x08 STATUS (RO, [NUM_LEDS-1:0] = LED); 0x0C ID (RO, 0x4C45_0000 | NUM_LEDS); 0x10+4n CHn for n<NUM_LEDS: [1:0] MODE, [15:8] DUTY, [31:16] HALF (RW).
REQ-013 Write: AWREADY and WREADY SHALL pulse together for one cycle only when AWVALID and WVALID are both high and BVALID is low; either channel may arrive first and waits.
REQ-014 Write commit SHALL happen in the handshake cycle, honouring WSTRB per byte; BVALID SHALL assert the next cycle and hold until BREADY.
REQ-015 Read: ARREADY SHALL pulse one cycle when ARVALID high and RVALID low; RVALID with RDATA SHALL assert the next cycle and hold stable until RREADY.
REQ-016 Unmapped addresses (above the last CHn) or writes to STATUS/ID SHALL return SLVERR (2'b10), with no state change; reads of unmapped addresses return RDATA 0; mapped accesses return OKAY.
REQ-017 Unimplemented register bits SHALL read 0; AWADDR/ARADDR[1:0] SHALL be ignored.
REQ-018 Tick: prescale counter counts 0..PRESCALE; one-cycle tick when it equals PRESCALE, then restarts at 0; any PRESCALE write clears the counter.
REQ-019 PWM counter: 8 bits, increments on tick, wraps 255->0, shared by all channels.
REQ-020 MODE 0 = off, 1 = on, 2 = PWM (on while pwm_cnt < DUTY; DUTY 0 always off), 3 = blink.
REQ-021 Blink: per-channel 16-bit counter increments on tick; when it equals HALF the channel phase toggles and the counter clears; HALF 0 toggles on every tick.
REQ-022 Writing CHn SHALL clear channel n's blink counter and phase to 0.
REQ-023 CTRL.EN = 0 SHALL force LED to 0 and hold the prescale, PWM and blink counters at 0.
REQ-024 LED SHALL be registered, reflecting register/counter state with exactly 1-cycle latency.
REQ-025 Simultaneous read and write SHALL both proceed independently; a read of a register written the same cycle returns the old value.

Reset
REQ-026 On ARESET high, immediately: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, LED 0, CTRL 0, PRESCALE = PRESCALE_RST, all CHn 0, all counters and phases 0.
REQ-027 Reset mid-transaction SHALL abort it; no response is issued after release.

Configuration
REQ-028 With macro AXIL_LED_CTRL_BLINK_EN defined, MODE 3 and HALF SHALL behave per REQ-021/022.
REQ-029 Without AXIL_LED_CTRL_BLINK_EN, no blink counters SHALL exist; MODE 3 drives LED 0 and HALF reads 0 (writes discarded).

Verification
REQ-030 Write CH0..CH3 = 0x0001_0000+i, read back -> values match, RRESP OKAY; read 0x0C -> 0x4C45_0004.
REQ-031 PRESCALE=0, EN=1, CH0 MODE 2 DUTY 0x40 -> LED[0] high exactly 64 of every 256 cycles.
REQ-032 PRESCALE=0, EN=1, CH1 MODE 3 HALF 3 -> LED[1] toggles every 4 cycles (BLINK_EN defined); stays 0 (undefined).
REQ-033 AWVALID 3 cycles before WVALID -> single AW/W handshake when WVALID rises, one BVALID; BREADY held low 5 cycles -> BVALID held.
REQ-034 Read 0x50 with NUM_LEDS=4 -> RRESP 2'b10, RDATA 0; write 0x08 -> BRESP 2'b10, STATUS unchanged.
REQ-035 Assert ARESET while BVALID high and LED[0]=1 -> BVALID 0, LED 0, CTRL reads 0 after release.
